// File: rtl/reg_file_loader.sv
// rtl/reg_file_loader.sv - loads three 32-bit words from a byte stream into the register file, then replays them
// Sole master of the register file write/address ports; every output is registered.
module reg_file_loader #(
  parameter logic [3:0]  ADD_REG0    = 4'd0,
  parameter logic [3:0]  ADD_REG1    = 4'd1,
  parameter logic [3:0]  ADD_REG2    = 4'd2,
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic        o_rf_wr,
  output logic [3:0]  o_rf_address_write,
  output logic [1:0]  o_rf_address_read,
  output logic [31:0] o_rf_data,
  input  logic [32:0] i_rf_out_data,
  output logic [32:0] o_inst_data,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic        o_busy,
  output logic        o_timeout_err,
  output logic        o_overrun_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_WRITE, S_RD_ADDR, S_RD_WAIT, S_EMIT
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_word, w_word_nxt;
  logic [1:0]  r_byte_cnt, w_byte_cnt_nxt;
  logic [1:0]  r_word_idx, w_word_idx_nxt;
  logic [1:0]  r_rd_idx, w_rd_idx_nxt;
  logic [15:0] r_to_cnt, w_to_cnt_nxt;

  logic        r_rx_ready, w_rx_ready_nxt;
  logic        r_rf_wr, w_rf_wr_nxt;
  logic [3:0]  r_rf_address_write, w_rf_address_write_nxt;
  logic [1:0]  r_rf_address_read, w_rf_address_read_nxt;
  logic [31:0] r_rf_data, w_rf_data_nxt;
  logic [32:0] r_inst_data, w_inst_data_nxt;
  logic        r_inst_valid, w_inst_valid_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_timeout_err, w_timeout_err_nxt;
  logic        r_overrun_err, w_overrun_err_nxt;

  logic        w_rx_open;
  logic        w_timeout;
  logic [3:0]  w_slot_addr;

  assign w_rx_open = (r_state == S_IDLE) || (r_state == S_COLLECT);
  // An arriving byte always beats an expiring counter.
  assign w_timeout = (r_state == S_COLLECT) && !i_rx_valid &&
                     (r_to_cnt == TIMEOUT_CYC - 16'd1);

  always_comb begin
    case (r_word_idx)
      2'd0:    w_slot_addr = ADD_REG0;
      2'd1:    w_slot_addr = ADD_REG1;
      default: w_slot_addr = ADD_REG2;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state            <= S_IDLE;
      r_word             <= 32'd0;
      r_byte_cnt         <= 2'd0;
      r_word_idx         <= 2'd0;
      r_rd_idx           <= 2'd0;
      r_to_cnt           <= 16'd0;
      r_rx_ready         <= 1'b1;
      r_rf_wr            <= 1'b0;
      r_rf_address_write <= 4'd0;
      r_rf_address_read  <= 2'b11;
      r_rf_data          <= 32'd0;
      r_inst_data        <= 33'd0;
      r_inst_valid       <= 1'b0;
      r_busy             <= 1'b0;
      r_timeout_err      <= 1'b0;
      r_overrun_err      <= 1'b0;
    end else begin
      r_state            <= w_state_nxt;
      r_word             <= w_word_nxt;
      r_byte_cnt         <= w_byte_cnt_nxt;
      r_word_idx         <= w_word_idx_nxt;
      r_rd_idx           <= w_rd_idx_nxt;
      r_to_cnt           <= w_to_cnt_nxt;
      r_rx_ready         <= w_rx_ready_nxt;
      r_rf_wr            <= w_rf_wr_nxt;
      r_rf_address_write <= w_rf_address_write_nxt;
      r_rf_address_read  <= w_rf_address_read_nxt;
      r_rf_data          <= w_rf_data_nxt;
      r_inst_data        <= w_inst_data_nxt;
      r_inst_valid       <= w_inst_valid_nxt;
      r_busy             <= w_busy_nxt;
      r_timeout_err      <= w_timeout_err_nxt;
      r_overrun_err      <= w_overrun_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_word_nxt     = r_word;
    w_byte_cnt_nxt = r_byte_cnt;
    w_word_idx_nxt = r_word_idx;
    w_rd_idx_nxt   = r_rd_idx;
    w_to_cnt_nxt   = r_to_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_rx_valid) begin
          w_word_nxt     = {24'd0, i_rx_data};
          w_byte_cnt_nxt = 2'd1;
          w_word_idx_nxt = 2'd0;
          w_to_cnt_nxt   = 16'd0;
          w_state_nxt    = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (i_rx_valid) begin
          w_word_nxt[{r_byte_cnt, 3'b000} +: 8] = i_rx_data;
          w_byte_cnt_nxt = r_byte_cnt + 2'd1;
          w_to_cnt_nxt   = 16'd0;
          if (r_byte_cnt == 2'd3) w_state_nxt = S_WRITE;
        end else if (w_timeout) begin
          w_byte_cnt_nxt = 2'd0;
          w_word_idx_nxt = 2'd0;
          w_to_cnt_nxt   = 16'd0;
          w_state_nxt    = S_IDLE;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 16'd1;
        end
      end
      S_WRITE: begin
        if (r_word_idx == 2'd2) begin
          w_rd_idx_nxt = 2'd0;
          w_state_nxt  = S_RD_ADDR;
        end else begin
          w_word_idx_nxt = r_word_idx + 2'd1;
          w_state_nxt    = S_COLLECT;
        end
      end
      S_RD_ADDR: w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: w_state_nxt = S_EMIT;
      S_EMIT: begin
        if (i_inst_ready) begin
          if (r_rd_idx == 2'd2) begin
            w_word_idx_nxt = 2'd0;
            w_byte_cnt_nxt = 2'd0;
            w_state_nxt    = S_IDLE;
          end else begin
            w_rd_idx_nxt = r_rd_idx + 2'd1;
            w_state_nxt  = S_RD_ADDR;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered copies line up with it.
  always_comb begin
    w_rx_ready_nxt         = (w_state_nxt == S_IDLE) || (w_state_nxt == S_COLLECT);
    w_busy_nxt             = (w_state_nxt != S_IDLE);
    w_rf_wr_nxt            = (w_state_nxt == S_WRITE);
    w_inst_valid_nxt       = (w_state_nxt == S_EMIT);
    w_timeout_err_nxt      = w_timeout;
    w_overrun_err_nxt      = i_rx_valid && !w_rx_open;
    w_rf_address_write_nxt = r_rf_address_write;
    w_rf_data_nxt          = r_rf_data;
    w_rf_address_read_nxt  = r_rf_address_read;
    w_inst_data_nxt        = r_inst_data;
    if (w_state_nxt == S_WRITE) begin
      w_rf_address_write_nxt = w_slot_addr;
      w_rf_data_nxt          = w_word_nxt;
    end
    if (w_state_nxt == S_RD_ADDR)
      w_rf_address_read_nxt = w_rd_idx_nxt;
    else if ((r_state == S_EMIT) && (w_state_nxt == S_IDLE))
      w_rf_address_read_nxt = 2'b11;
    if (r_state == S_RD_WAIT)
      w_inst_data_nxt = i_rf_out_data;
  end

  assign o_rx_ready         = r_rx_ready;
  assign o_rf_wr            = r_rf_wr;
  assign o_rf_address_write = r_rf_address_write;
  assign o_rf_address_read  = r_rf_address_read;
  assign o_rf_data          = r_rf_data;
  assign o_inst_data        = r_inst_data;
  assign o_inst_valid       = r_inst_valid;
  assign o_busy             = r_busy;
  assign o_timeout_err      = r_timeout_err;
  assign o_overrun_err      = r_overrun_err;

endmodule

// File: tb/tb_reg_file_loader.sv
// tb/tb_reg_file_loader.sv - directed bench for reg_file_loader with a behavioural three-slot register file
module tb_reg_file_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        rf_wr;
  logic [3:0]  rf_address_write;
  logic [1:0]  rf_address_read;
  logic [31:0] rf_data;
  logic [32:0] rf_out_data = 33'd0;
  logic [32:0] inst_data;
  logic        inst_valid;
  logic        inst_ready;
  logic        busy;
  logic        timeout_err;
  logic        overrun_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_to = 0;
  int n_ov = 0;

  logic [3:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  logic [32:0] em_data_q[$];
  int          em_cyc_q[$];
  logic [32:0] rf_slots[0:2] = '{default: 33'd0};

  always #5 clk = ~clk;

  reg_file_loader #(.TIMEOUT_CYC(16'd16)) dut (
    .i_clk(clk), .i_reset(reset), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_rx_ready(rx_ready), .o_rf_wr(rf_wr), .o_rf_address_write(rf_address_write),
    .o_rf_address_read(rf_address_read), .o_rf_data(rf_data), .i_rf_out_data(rf_out_data),
    .o_inst_data(inst_data), .o_inst_valid(inst_valid), .i_inst_ready(inst_ready),
    .o_busy(busy), .o_timeout_err(timeout_err), .o_overrun_err(overrun_err)
  );

  // External register file: registered read, slot 2 carries the flag bit.
  always @(posedge clk) begin
    if (rf_wr && rf_address_write < 4'd3)
      rf_slots[rf_address_write[1:0]] <= {rf_address_write == 4'd2, rf_data};
    rf_out_data <= (rf_address_read == 2'b11) ? 33'd0 : rf_slots[rf_address_read];
  end

  always @(posedge clk) begin
    if (rf_wr) begin
      wr_addr_q.push_back(rf_address_write);
      wr_data_q.push_back(rf_data);
      wr_cyc_q.push_back(cyc);
    end
    if (inst_valid && inst_ready) begin
      em_data_q.push_back(inst_data);
      em_cyc_q.push_back(cyc);
    end
    if (timeout_err) n_to = n_to + 1;
    if (overrun_err) n_ov = n_ov + 1;
    cyc <= cyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [7:0] base, input int i);
    logic [7:0] b;
    b = base + 8'(4 * i);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    em_data_q.delete(); em_cyc_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!rx_ready && n < 20) begin tick(); n++; end
    if (!rx_ready) chk("send rx_ready", rx_ready, 1);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] base);
    for (int i = 0; i < 12; i++) send_byte(base + 8'(i));
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!inst_valid && n < 40) begin tick(); n++; end
    chk({tag, " valid"}, inst_valid, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || inst_valid) && n < 80) begin tick(); n++; end
    chk({tag, " idle"}, busy, 0);
  endtask

  task automatic check_packet(input logic [7:0] base, input string tag);
    chk({tag, " nwr"}, wr_addr_q.size(), 3);
    chk({tag, " nem"}, em_data_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < wr_addr_q.size()) begin
        chk($sformatf("%s wr%0d addr", tag, i), wr_addr_q[i], i);
        chk($sformatf("%s wr%0d data", tag, i), wr_data_q[i], exp_word(base, i));
      end
      if (i < em_data_q.size())
        chk($sformatf("%s em%0d", tag, i), em_data_q[i], {i == 2, exp_word(base, i)});
    end
  endtask

  initial begin
    int          n;
    logic [32:0] d0;
    logic [1:0]  a0;
    logic        stable;

    reset = 1'b1; rx_data = 8'd0; rx_valid = 1'b0; inst_ready = 1'b1;
    tick(); tick();
    chk("rst rx_ready", rx_ready, 1);
    chk("rst rf_wr", rf_wr, 0);
    chk("rst rf_address_read", rf_address_read, 2'b11);
    chk("rst rf_address_write", rf_address_write, 0);
    chk("rst rf_data", rf_data, 0);
    chk("rst inst", {inst_valid, inst_data}, 0);
    chk("rst flags", {busy, timeout_err, overrun_err}, 0);
    reset = 1'b0;
    tick();

    // Basic packet and latency
    clear_logs();
    send_packet(8'h01);
    n = cyc - 1;
    chk("basic rf_wr N+1", rf_wr, 1);
    chk("basic addr2", rf_address_write, 2);
    chk("basic data2", rf_data, 32'h0C0B0A09);
    tick();
    chk("basic rd_addr N+2", {rf_wr, rf_address_read}, 3'b000);
    wait_idle("basic");
    check_packet(8'h01, "basic");
    chk("basic rf_address_read end", rf_address_read, 2'b11);
    if (em_cyc_q.size() == 3) begin
      chk("basic lat0", em_cyc_q[0], n + 4);
      chk("basic lat1", em_cyc_q[1], n + 7);
      chk("basic lat2", em_cyc_q[2], n + 10);
    end
    if (wr_cyc_q.size() == 3) chk("basic wr lat", wr_cyc_q[2], n + 1);

    // Backpressure
    clear_logs();
    inst_ready = 1'b0;
    send_packet(8'h81);
    for (int e = 0; e < 3; e++) begin
      wait_valid("bp");
      d0 = inst_data; a0 = rf_address_read; stable = 1'b1;
      repeat (20) begin
        tick();
        if (!inst_valid || inst_data !== d0 || rf_address_read !== a0) stable = 1'b0;
      end
      chk($sformatf("bp%0d stable", e), stable, 1);
      chk($sformatf("bp%0d data", e), d0, {e == 2, exp_word(8'h81, e)});
      chk($sformatf("bp%0d rd_addr", e), a0, e);
      inst_ready = 1'b1; tick(); inst_ready = 1'b0;
    end
    inst_ready = 1'b1;
    wait_idle("bp");
    check_packet(8'h81, "bp");

    // Overrun during WRITE and EMIT
    clear_logs();
    n_ov = 0;
    for (int i = 0; i < 4; i++) send_byte(8'h01 + 8'(i));
    chk("ovr write rx_ready", rx_ready, 0);
    rx_data = 8'hAA; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    chk("ovr write pulse", overrun_err, 1);
    tick();
    chk("ovr write pulse end", overrun_err, 0);
    for (int i = 4; i < 12; i++) send_byte(8'h01 + 8'(i));
    inst_ready = 1'b0;
    wait_valid("ovr");
    rx_data = 8'hAA; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    chk("ovr emit pulse", overrun_err, 1);
    inst_ready = 1'b1;
    wait_idle("ovr");
    chk("ovr count", n_ov, 2);
    check_packet(8'h01, "ovr");
    clear_logs();
    send_packet(8'h10);
    wait_idle("ovr next");
    check_packet(8'h10, "ovr next");

    // Timeout after six bytes
    clear_logs();
    n_to = 0;
    for (int i = 0; i < 6; i++) send_byte(8'h21 + 8'(i));
    repeat (15) tick();
    chk("to before", {timeout_err, busy}, 2'b01);
    tick();
    chk("to pulse", timeout_err, 1);
    chk("to idle", {busy, rx_ready}, 2'b01);
    tick();
    chk("to pulse end", timeout_err, 0);
    chk("to count", n_to, 1);
    chk("to nwr", wr_addr_q.size(), 1);
    if (wr_addr_q.size() > 0) chk("to slot0", {wr_addr_q[0], wr_data_q[0]}, {4'd0, 32'h24232221});
    clear_logs();
    send_packet(8'h31);
    wait_idle("to next");
    check_packet(8'h31, "to next");

    // Byte arriving on the expiry cycle
    n_to = 0;
    send_byte(8'h41);
    repeat (15) tick();
    rx_data = 8'h42; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    chk("race no pulse", {timeout_err, busy}, 2'b01);
    repeat (15) tick();
    chk("race restart", n_to, 0);
    tick();
    chk("race later pulse", {timeout_err, busy}, 2'b10);
    tick();

    // Reset while the second entry is being offered
    clear_logs();
    inst_ready = 1'b0;
    send_packet(8'h51);
    wait_valid("rst0");
    inst_ready = 1'b1; tick(); inst_ready = 1'b0;
    wait_valid("rst1");
    reset = 1'b1;
    tick();
    chk("mid rst rf_address_read", rf_address_read, 2'b11);
    chk("mid rst inst", {inst_valid, inst_data}, 0);
    chk("mid rst flags", {busy, rx_ready, rf_wr, timeout_err, overrun_err}, 5'b01000);
    chk("mid rst wr port", {rf_address_write, rf_data}, 0);
    reset = 1'b0; inst_ready = 1'b1;
    tick();
    clear_logs();
    send_packet(8'h61);
    wait_idle("post rst");
    check_packet(8'h61, "post rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
